tile_row_prefetcher: RTL

//  Sequences the background tile generator: before each tile row is displayed, it walks

---
 rtl/tile_row_prefetcher.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tile_row_prefetcher.sv
// rtl/tile_row_prefetcher.sv - double-buffered tile row cache filled from a generator port shared with a query port
module tile_row_prefetcher #(
    parameter int TILES_PER_ROW = 80,
    parameter int GAP_TILE      = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_row_req,
    input  logic [6:0] i_row,
    input  logic       i_swap,
    output logic [6:0] o_gen_tile_x,
    output logic [6:0] o_gen_tile_y,
    input  logic [3:0] i_gen_tile_no,
    input  logic [6:0] i_rd_tile_x,
    output logic [3:0] o_rd_tile_no,
    input  logic       i_q_valid,
    input  logic [6:0] i_q_tile_x,
    input  logic [6:0] i_q_tile_y,
    output logic       o_q_ready,
    output logic       o_q_valid,
    output logic [3:0] o_q_tile_no,
    output logic       o_busy,
    output logic       o_row_ready,
    output logic       o_underrun
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [6:0] LAST_COL = 7'(TILES_PER_ROW - 1);
    localparam logic [6:0] NUM_COLS = 7'(TILES_PER_ROW);
    localparam logic [3:0] GAP_NO   = 4'(GAP_TILE);

    state_t     state_q, state_d;
    logic [6:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic       front_q, front_d;
    logic       row_ready_q, row_ready_d;
    logic       underrun_q, underrun_d;
    logic       wrote_q;
    logic       q_valid_q;
    logic [3:0] q_tile_no_q, q_tile_no_d;
    logic [3:0] rd_tile_no_q;
    logic       q_accept;
    logic       fill_we;

    logic [3:0] bank0 [TILES_PER_ROW];
    logic [3:0] bank1 [TILES_PER_ROW];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        front_d     = front_q;
        row_ready_d = row_ready_q;
        underrun_d  = underrun_q;

        // Query wins only after a fill write, so neither side starves.
        o_q_ready    = (state_q == IDLE) || wrote_q;
        q_accept     = i_q_valid && o_q_ready;
        fill_we      = (state_q == FILL) && !q_accept && !i_row_req;
        o_gen_tile_x = q_accept ? i_q_tile_x : col_q;
        o_gen_tile_y = q_accept ? i_q_tile_y : row_q;
        q_tile_no_d  = q_accept ? i_gen_tile_no : q_tile_no_q;

        if (fill_we) begin
            col_d = col_q + 7'd1;
        end

        if (i_swap) begin
            if (row_ready_q) begin
                front_d     = !front_q;
                row_ready_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Swap is resolved above first, so a simultaneous request fills the new back bank.
        if (i_row_req) begin
            state_d     = FILL;
            col_d       = 7'd0;
            row_d       = i_row;
            row_ready_d = 1'b0;
        end else if (fill_we && (col_q == LAST_COL)) begin
            state_d     = IDLE;
            col_d       = 7'd0;
            row_ready_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            col_q        <= 7'd0;
            row_q        <= 7'd0;
            front_q      <= 1'b0;
            row_ready_q  <= 1'b0;
            underrun_q   <= 1'b0;
            wrote_q      <= 1'b0;
            q_valid_q    <= 1'b0;
            q_tile_no_q  <= 4'd0;
            rd_tile_no_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            front_q      <= front_d;
            row_ready_q  <= row_ready_d;
            underrun_q   <= underrun_d;
            wrote_q      <= fill_we;
            q_valid_q    <= q_accept;
            q_tile_no_q  <= q_tile_no_d;
            if (i_rd_tile_x < NUM_COLS) begin
                rd_tile_no_q <= front_q ? bank1[i_rd_tile_x] : bank0[i_rd_tile_x];
            end else begin
                rd_tile_no_q <= GAP_NO;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (fill_we) begin
            if (front_q) begin
                bank0[col_q] <= i_gen_tile_no;
            end else begin
                bank1[col_q] <= i_gen_tile_no;
            end
        end
    end

    assign o_rd_tile_no = rd_tile_no_q;
    assign o_q_valid    = q_valid_q;
    assign o_q_tile_no  = q_tile_no_q;
    assign o_busy       = (state_q == FILL);
    assign o_row_ready  = row_ready_q;
    assign o_underrun   = underrun_q;

endmodule
